// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - single-lane SPI flash responder (READ, FAST_READ, READ_ID) backed by a byte-wide sync memory
// Oversamples sck/cs_n/mosi in clk; mosi sampled on sck rise, miso updated on sck fall.
module qspi_flash_responder #(
  parameter int          ADDR_W     = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter int          FAST_DUMMY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err_underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  state_t      state, state_nx;
  logic [1:0]  sck_sync, cs_sync, mosi_sync;
  logic        sck_d;
  logic        sck_rise, sck_fall, cs_hi, mosi_s;
  logic [22:0] shift_sr;
  logic [23:0] sr_next;
  logic [7:0]  cmd_byte;
  logic [4:0]  cnt;
  logic [2:0]  dcnt;
  logic        fast, id_mode;
  logic [1:0]  id_idx;
  logic [7:0]  tx_byte, tx_shift;
  logic        tx_valid, rd_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck_i};
      cs_sync   <= {cs_sync[0], spi_cs_n_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      sck_d     <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] & sck_d;
  assign cs_hi    = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sr_next  = {shift_sr, mosi_s};
  assign cmd_byte = sr_next[7:0];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!cs_hi) state_nx = CMD;
      CMD: begin
        if (sck_rise && cnt == 5'd7) begin
          case (cmd_byte)
            8'h03, 8'h0B: state_nx = ADDR;
            8'h9F:        state_nx = DATA;
            default:      state_nx = IGNORE;
          endcase
        end
      end
      ADDR:  if (sck_rise && cnt == 5'd23) state_nx = (fast && FAST_DUMMY != 0) ? DUMMY : DATA;
      DUMMY: if (sck_rise && cnt == 5'(FAST_DUMMY - 1)) state_nx = DATA;
      default: state_nx = state;
    endcase
    // Deselect wins over any coincident sck edge.
    if (cs_hi) state_nx = IDLE;
  end

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_miso_o   <= 1'b0;
      spi_miso_oe  <= 1'b0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      err_underrun <= 1'b0;
      shift_sr     <= '0;
      cnt          <= '0;
      dcnt         <= '0;
      fast         <= 1'b0;
      id_mode      <= 1'b0;
      id_idx       <= '0;
      tx_byte      <= '0;
      tx_shift     <= '0;
      tx_valid     <= 1'b0;
      rd_pend      <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      // Memory returns data one clk after the strobe; pick it up the clk after that.
      rd_pend <= mem_en;
      if (rd_pend) begin
        tx_byte  <= mem_rdata;
        tx_valid <= 1'b1;
      end
      if (cs_hi) begin
        cnt         <= '0;
        dcnt        <= '0;
        spi_miso_oe <= 1'b0;
        id_mode     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt  <= '0;
            dcnt <= '0;
          end
          CMD: begin
            if (sck_rise) begin
              shift_sr <= sr_next[22:0];
              cnt      <= cnt + 5'd1;
              if (cnt == 5'd7) begin
                cnt  <= '0;
                fast <= (cmd_byte == 8'h0B);
                if (cmd_byte == 8'h9F) begin
                  id_mode  <= 1'b1;
                  tx_byte  <= JEDEC_ID[23:16];
                  tx_valid <= 1'b1;
                  id_idx   <= 2'd1;
                end
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              shift_sr <= sr_next[22:0];
              cnt      <= cnt + 5'd1;
              if (cnt == 5'd23) begin
                cnt      <= '0;
                mem_en   <= 1'b1;
                mem_addr <= sr_next[ADDR_W-1:0];
              end
            end
          end
          DUMMY: begin
            if (sck_rise) cnt <= cnt + 5'd1;
          end
          DATA: begin
            if (sck_fall) begin
              dcnt        <= dcnt + 3'd1;
              spi_miso_oe <= 1'b1;
              if (dcnt == 3'd0) begin
                tx_valid <= 1'b0;
                if (tx_valid) begin
                  spi_miso_o <= tx_byte[7];
                  tx_shift   <= {tx_byte[6:0], 1'b0};
                end else begin
                  spi_miso_o   <= 1'b1;
                  tx_shift     <= 8'hFE;
                  err_underrun <= 1'b1;
                end
                if (id_mode) begin
                  tx_byte  <= id_byte(id_idx);
                  tx_valid <= 1'b1;
                  if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                end
              end else begin
                spi_miso_o <= tx_shift[7];
                tx_shift   <= {tx_shift[6:0], 1'b0};
              end
              // bit0 is going out: prefetch the next byte while it is on the wire.
              if (dcnt == 3'd7 && !id_mode) begin
                mem_en   <= 1'b1;
                mem_addr <= mem_addr + 1'b1;
              end
            end
          end
          IGNORE: spi_miso_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
